// File: rtl/bf16_pack.sv
// rtl/bf16_pack.sv - FP32 to BF16 round-to-nearest-even packer with BF16 to FP32 widener
//
// Two independent single-cycle paths share only the clock and reset.
//   clk_i           rising-edge clock
//   rst_ni          asynchronous active-low reset, clears every output register
//   pack_valid_i    f32_i carries an operand this cycle
//   f32_i[31:0]     binary32 operand to narrow
//   unpack_valid_i  bf16_i carries an operand this cycle
//   bf16_i[15:0]    bfloat16 operand to widen
//   pack_valid_o    bf16_o / inexact_o / overflow_o hold a fresh result
//   bf16_o[15:0]    rounded bfloat16 result
//   inexact_o       discarded low half was nonzero (never set for NaN)
//   overflow_o      finite operand rounded up to +/-Inf
//   unpack_valid_o  f32_o holds a fresh result
//   f32_o[31:0]     exact binary32 widening of bf16_i
// Data and flag registers only load on a valid cycle and otherwise hold.

module bf16_pack (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pack_valid_i,
    input  logic [31:0] f32_i,
    input  logic        unpack_valid_i,
    input  logic [15:0] bf16_i,
    output logic        pack_valid_o,
    output logic [15:0] bf16_o,
    output logic        inexact_o,
    output logic        overflow_o,
    output logic        unpack_valid_o,
    output logic [31:0] f32_o
);

    logic        exp_max;
    logic        is_nan;
    logic        round_up;
    logic [14:0] rounded_mag;
    logic [15:0] pack_d;
    logic        inexact_d;
    logic        overflow_d;

    always_comb begin
        exp_max  = &f32_i[30:23];
        is_nan   = exp_max & (|f32_i[22:0]);
        // RNE: round up when guard is set and either sticky or lsb is set (tie -> even).
        round_up = f32_i[15] & ((|f32_i[14:0]) | f32_i[16]);
        // Rounding only touches exponent+mantissa; the sign bit is carried across
        // untouched. A mantissa carry ripples into the exponent, so 0x7F7F+1 -> 0x7F80.
        rounded_mag = f32_i[30:16] + {14'd0, round_up};

        if (is_nan) begin
            // Quiet bit forced so a signalling NaN whose payload sits only in
            // the discarded half cannot collapse into Inf.
            pack_d = {f32_i[31], 8'hFF, 1'b1, f32_i[21:16]};
        end else begin
            pack_d = {f32_i[31], rounded_mag};
        end

        inexact_d  = ~is_nan & (|f32_i[15:0]);
        // Inf inputs never round (low half zero), so exp_max excludes them here.
        overflow_d = ~exp_max & (&rounded_mag[14:7]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pack_valid_o <= 1'b0;
            bf16_o       <= 16'h0000;
            inexact_o    <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            pack_valid_o <= pack_valid_i;
            if (pack_valid_i) begin
                bf16_o     <= pack_d;
                inexact_o  <= inexact_d;
                overflow_o <= overflow_d;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            unpack_valid_o <= 1'b0;
            f32_o          <= 32'h0000_0000;
        end else begin
            unpack_valid_o <= unpack_valid_i;
            if (unpack_valid_i) begin
                f32_o <= {bf16_i, 16'h0000};
            end
        end
    end

endmodule

// File: tb/tb_bf16_pack.sv
// tb/tb_bf16_pack.sv - self-checking bench for bf16_pack

module tb_bf16_pack;

    logic        clk_i;
    logic        rst_ni;
    logic        pack_valid_i;
    logic [31:0] f32_i;
    logic        unpack_valid_i;
    logic [15:0] bf16_i;
    logic        pack_valid_o;
    logic [15:0] bf16_o;
    logic        inexact_o;
    logic        overflow_o;
    logic        unpack_valid_o;
    logic [31:0] f32_o;

    int n_cmp;
    int n_err;

    // Last results the outputs should be holding.
    logic [15:0] hold_bf16;
    logic        hold_inx;
    logic        hold_ovf;
    logic [31:0] hold_f32;

    bf16_pack dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .pack_valid_i   (pack_valid_i),
        .f32_i          (f32_i),
        .unpack_valid_i (unpack_valid_i),
        .bf16_i         (bf16_i),
        .pack_valid_o   (pack_valid_o),
        .bf16_o         (bf16_o),
        .inexact_o      (inexact_o),
        .overflow_o     (overflow_o),
        .unpack_valid_o (unpack_valid_o),
        .f32_o          (f32_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: treat the operand as an integer with 16 fraction bits to drop,
    // round the quotient to nearest with ties to even, then patch specials.
    task automatic ref_pack(input logic [31:0] f, output logic [15:0] r,
                            output logic inx, output logic ovf);
        int unsigned hi;
        int unsigned lo;
        int unsigned expo;
        int unsigned man;
        hi   = f >> 16;
        lo   = f & 32'hFFFF;
        expo = (f >> 23) & 32'hFF;
        man  = f & 32'h7F_FFFF;
        if (expo == 255 && man != 0) begin
            r   = 16'((f >> 16) & 32'h8000) | 16'h7FC0 | 16'((f >> 16) & 32'h3F);
            inx = 1'b0;
            ovf = 1'b0;
        end else begin
            if (lo > 32'h8000 || (lo == 32'h8000 && (hi % 2) == 1))
                hi = hi + 1;
            r   = hi[15:0];
            inx = (lo != 0);
            ovf = (expo != 255) && (((hi >> 7) & 32'hFF) == 255);
        end
    endtask

    // Apply one cycle of stimulus and check the registered outputs #1 after the edge.
    task automatic cycle(input logic pv, input logic [31:0] f, input logic uv, input logic [15:0] b,
                         input string tag);
        logic [15:0] r;
        logic        inx;
        logic        ovf;
        pack_valid_i   = pv;
        f32_i          = f;
        unpack_valid_i = uv;
        bf16_i         = b;
        @(posedge clk_i);
        #1;
        if (pv) begin
            ref_pack(f, r, inx, ovf);
            hold_bf16 = r;
            hold_inx  = inx;
            hold_ovf  = ovf;
        end
        if (uv) hold_f32 = b * 32'd65536;
        check({tag, ".pvalid"}, {31'd0, pack_valid_o}, {31'd0, pv});
        check({tag, ".uvalid"}, {31'd0, unpack_valid_o}, {31'd0, uv});
        check({tag, ".bf16"}, {16'd0, bf16_o}, {16'd0, hold_bf16});
        check({tag, ".inexact"}, {31'd0, inexact_o}, {31'd0, hold_inx});
        check({tag, ".overflow"}, {31'd0, overflow_o}, {31'd0, hold_ovf});
        check({tag, ".f32"}, f32_o, hold_f32);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pvalid"}, {31'd0, pack_valid_o}, 32'd0);
        check({tag, ".uvalid"}, {31'd0, unpack_valid_o}, 32'd0);
        check({tag, ".bf16"}, {16'd0, bf16_o}, 32'd0);
        check({tag, ".f32"}, f32_o, 32'd0);
        check({tag, ".inexact"}, {31'd0, inexact_o}, 32'd0);
        check({tag, ".overflow"}, {31'd0, overflow_o}, 32'd0);
    endtask

    logic [31:0] dir_in  [12];
    logic [15:0] dir_out [12];
    logic        dir_inx [12];
    logic        dir_ovf [12];

    initial begin
        n_cmp = 0;
        n_err = 0;
        hold_bf16 = '0; hold_inx = 1'b0; hold_ovf = 1'b0; hold_f32 = '0;
        rst_ni = 1'b0;
        pack_valid_i = 1'b0; f32_i = '0; unpack_valid_i = 1'b0; bf16_i = '0;

        dir_in[0]  = 32'h40490FDB; dir_out[0]  = 16'h4049; dir_inx[0]  = 1; dir_ovf[0]  = 0;
        dir_in[1]  = 32'hC0490FDB; dir_out[1]  = 16'hC049; dir_inx[1]  = 1; dir_ovf[1]  = 0;
        dir_in[2]  = 32'h00007FFF; dir_out[2]  = 16'h0000; dir_inx[2]  = 1; dir_ovf[2]  = 0;
        dir_in[3]  = 32'h00008000; dir_out[3]  = 16'h0000; dir_inx[3]  = 1; dir_ovf[3]  = 0;
        dir_in[4]  = 32'h00008001; dir_out[4]  = 16'h0001; dir_inx[4]  = 1; dir_ovf[4]  = 0;
        dir_in[5]  = 32'h80008001; dir_out[5]  = 16'h8001; dir_inx[5]  = 1; dir_ovf[5]  = 0;
        dir_in[6]  = 32'h7F7F7FFF; dir_out[6]  = 16'h7F7F; dir_inx[6]  = 1; dir_ovf[6]  = 0;
        dir_in[7]  = 32'h7F7F8000; dir_out[7]  = 16'h7F80; dir_inx[7]  = 1; dir_ovf[7]  = 1;
        dir_in[8]  = 32'hFF7F8000; dir_out[8]  = 16'hFF80; dir_inx[8]  = 1; dir_ovf[8]  = 1;
        dir_in[9]  = 32'h7F800000; dir_out[9]  = 16'h7F80; dir_inx[9]  = 0; dir_ovf[9]  = 0;
        dir_in[10] = 32'h7F800001; dir_out[10] = 16'h7FC0; dir_inx[10] = 0; dir_ovf[10] = 0;
        dir_in[11] = 32'hFFFFFFFF; dir_out[11] = 16'hFFFF; dir_inx[11] = 0; dir_ovf[11] = 0;

        #12;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Directed table, checked against the literal expectations.
        for (int i = 0; i < 12; i++) begin
            pack_valid_i = 1'b1;
            f32_i        = dir_in[i];
            @(posedge clk_i);
            #1;
            check($sformatf("dir%0d.pvalid", i), {31'd0, pack_valid_o}, 32'd1);
            check($sformatf("dir%0d.bf16", i), {16'd0, bf16_o}, {16'd0, dir_out[i]});
            check($sformatf("dir%0d.inexact", i), {31'd0, inexact_o}, {31'd0, dir_inx[i]});
            check($sformatf("dir%0d.overflow", i), {31'd0, overflow_o}, {31'd0, dir_ovf[i]});
        end
        pack_valid_i = 1'b0;

        // Directed unpacks, same cycle as a pack to show the paths are independent.
        unpack_valid_i = 1'b1; bf16_i = 16'h4049; pack_valid_i = 1'b1; f32_i = 32'hC0490FDB;
        @(posedge clk_i); #1;
        check("unp4049", f32_o, 32'h40490000);
        check("unp4049.pack", {16'd0, bf16_o}, 32'h0000C049);
        unpack_valid_i = 1'b1; bf16_i = 16'hC049; pack_valid_i = 1'b0;
        @(posedge clk_i); #1;
        check("unpC049", f32_o, 32'hC0490000);
        check("unpC049.hold", {16'd0, bf16_o}, 32'h0000C049);
        unpack_valid_i = 1'b1; bf16_i = 16'h8001;
        @(posedge clk_i); #1;
        check("unp8001", f32_o, 32'h80010000);
        unpack_valid_i = 1'b0;
        hold_bf16 = 16'hC049; hold_inx = 1'b1; hold_ovf = 1'b0; hold_f32 = 32'h80010000;

        // Single pulse: nothing before the edge, result exactly one edge later, then idle.
        pack_valid_i = 1'b1; f32_i = 32'h3F80C000;
        #1;
        check("pulse.early", {31'd0, pack_valid_o}, 32'd0);
        @(posedge clk_i); #1;
        check("pulse.valid", {31'd0, pack_valid_o}, 32'd1);
        check("pulse.bf16", {16'd0, bf16_o}, 32'h00003F81);
        ref_pack(32'h3F80C000, hold_bf16, hold_inx, hold_ovf);
        cycle(1'b0, 32'h0, 1'b0, 16'h0, "pulse.idle");

        // Exhaustive unpack streaming back-to-back alongside random packs.
        for (int i = 0; i < 65536; i++) begin
            logic [31:0] f;
            logic        pv;
            f  = $urandom;
            pv = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0: f[30:23] = 8'hFF;
                1: f[15:0]  = 16'h8000;
                2: f[30:23] = 8'h00;
                3: begin f[30:16] = 15'h7F7F; f[15] = 1'b1; end
                default: ;
            endcase
            cycle(pv, f, 1'b1, 16'(i), "rand");
        end

        // Reset mid-stream: outputs clear without a clock edge.
        cycle(1'b1, 32'h40490FDB, 1'b1, 16'h1234, "pre_rst");
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_zero("async_rst");
        // Conversion launched while reset is held must be discarded.
        pack_valid_i = 1'b1; f32_i = 32'h3F800000; unpack_valid_i = 1'b1; bf16_i = 16'h3F80;
        @(posedge clk_i); #1;
        check_all_zero("rst_held");
        @(negedge clk_i);
        pack_valid_i = 1'b0; unpack_valid_i = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check_all_zero("post_rst");
        hold_bf16 = '0; hold_inx = 1'b0; hold_ovf = 1'b0; hold_f32 = '0;
        cycle(1'b1, 32'h7F7F8000, 1'b1, 16'hFF80, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
